glu_seq_ctrl: RTL and testbench

Sequencer for the GLU activation stage: on `start` it walks a buffer of `N_ELEM` value/gate pairs, drives each gate through the shared combinational `pwl_sigmoid` instance, and computes out = value × sigmoid(gate) in Q4.12. It writes each result to a destination buffer with a fixed pipeline latency. It sits between the layer output buffer and the activation buffer of the 3x3 GAN datapath and owns all read/write addressing for that stage.

---
 rtl/glu_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_glu_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glu_seq_ctrl.sv
// GLU activation sequencer: walks N_ELEM value/gate pairs and writes
// value * sigmoid(gate) in Q4.12, three cycles after each read is issued.
module glu_seq_ctrl #(
  parameter int N_ELEM = 9,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [15:0]       i_rd_value,
  input  logic [15:0]       i_rd_gate,
  output logic [15:0]       o_sig_in,
  input  logic [15:0]       i_sig_out,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_drain_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                w_kill;

  logic                r_s0_vld;
  logic [ADDR_W-1:0]   r_s0_addr;
  logic                r_v1;
  logic signed [15:0]  r_s1_value;
  logic signed [15:0]  r_s1_sig;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [15:0]         r_wr_data;

  logic signed [31:0]  w_prod;
  logic signed [31:0]  w_rnd;
  logic [15:0]         w_result;

  // Abort only has an effect once a run has left IDLE.
  assign w_kill = i_abort && (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start && !i_abort) w_state_next = S_RUN;
      S_RUN: begin
        if (i_abort)                     w_state_next = S_IDLE;
        else if (r_rd_addr == LAST_ADDR) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_abort)                 w_state_next = S_IDLE;
        else if (r_drain_cnt == 2'd2) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drain_cnt <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      r_busy      <= (w_state_next == S_RUN) || (w_state_next == S_DRAIN);
      r_done      <= (w_state_next == S_DONE);
      r_rd_en     <= (w_state_next == S_RUN);
      r_rd_addr   <= (r_state == S_RUN && w_state_next == S_RUN) ?
                     r_rd_addr + ADDR_W'(1) : '0;
    end
  end

  assign w_prod = 32'(r_s1_value) * 32'(r_s1_sig);
  assign w_rnd  = (w_prod + 32'sd2048) >>> 12;

  always_comb begin
    w_result = w_rnd[15:0];
    if (w_rnd > 32'sd32767)       w_result = 16'h7fff;
    else if (w_rnd < -32'sd32768) w_result = 16'h8000;
  end

  // Address rides with the data so writes never depend on the read counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s0_vld   <= 1'b0;
      r_s0_addr  <= '0;
      r_v1       <= 1'b0;
      r_s1_value <= '0;
      r_s1_sig   <= '0;
      r_s1_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_s0_vld   <= r_rd_en && !w_kill;
      r_s0_addr  <= r_rd_addr;
      r_v1       <= r_s0_vld && !w_kill;
      r_s1_value <= i_rd_value;
      r_s1_sig   <= i_sig_out;
      r_s1_addr  <= r_s0_addr;
      r_wr_en    <= r_v1 && !w_kill;
      if (r_v1) begin
        r_wr_addr <= r_s1_addr;
        r_wr_data <= w_result;
      end
    end
  end

  assign o_sig_in  = i_rd_gate;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_glu_seq_ctrl.sv
// Scoreboard bench for glu_seq_ctrl: a 9-element instance and a 1-element
// instance, each with a source buffer model and a behavioural sigmoid.
module tb_glu_seq_ctrl;
  localparam int AW = 4;
  typedef struct { logic [AW-1:0] addr; logic signed [15:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic signed [15:0] mem_v [16];
  logic signed [15:0] mem_g [16];
  logic signed [15:0] exp_v [16];
  exp_t q_a[$];
  exp_t q_b[$];

  logic          a_start = 1'b0, a_abort = 1'b0, b_start = 1'b0, b_abort = 1'b0;
  logic          a_busy, a_done, a_rd_en, a_wr_en, b_busy, b_done, b_rd_en, b_wr_en;
  logic [AW-1:0] a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;
  logic [15:0]   a_sig_in, a_sig_out, a_wr_data, b_sig_in, b_sig_out, b_wr_data;
  logic signed [15:0] a_rd_value = '0, a_rd_gate = '0, b_rd_value = '0, b_rd_gate = '0;

  // Piecewise-linear sigmoid stand-in: 0.5 + x/4, clamped to [0, 1].
  function automatic logic [15:0] sig_model(input logic signed [15:0] x);
    int y;
    y = 2048 + (int'(x) / 4);
    if (y < 0) y = 0;
    if (y > 4096) y = 4096;
    return 16'(y);
  endfunction

  // value * sigmoid(gate) rounded half up, saturated to 16 bits.
  function automatic logic signed [15:0] glu_ref(input logic signed [15:0] v,
                                                 input logic signed [15:0] g);
    real r;
    r = $floor(real'(int'(v)) * real'(int'(sig_model(g))) / 4096.0 + 0.5);
    if (r > 32767.0) r = 32767.0;
    if (r < -32768.0) r = -32768.0;
    return 16'($rtoi(r));
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  glu_seq_ctrl #(.N_ELEM(9), .ADDR_W(AW)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_abort(a_abort),
    .o_busy(a_busy), .o_done(a_done), .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr),
    .i_rd_value(a_rd_value), .i_rd_gate(a_rd_gate), .o_sig_in(a_sig_in),
    .i_sig_out(a_sig_out), .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr),
    .o_wr_data(a_wr_data));

  glu_seq_ctrl #(.N_ELEM(1), .ADDR_W(AW)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
    .o_busy(b_busy), .o_done(b_done), .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr),
    .i_rd_value(b_rd_value), .i_rd_gate(b_rd_gate), .o_sig_in(b_sig_in),
    .i_sig_out(b_sig_out), .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr),
    .o_wr_data(b_wr_data));

  assign a_sig_out = sig_model(a_sig_in);
  assign b_sig_out = sig_model(b_sig_in);

  always @(posedge clk) begin
    if (a_rd_en) begin
      a_rd_value <= mem_v[a_rd_addr];
      a_rd_gate  <= mem_g[a_rd_addr];
    end
    if (b_rd_en) begin
      b_rd_value <= mem_v[b_rd_addr];
      b_rd_gate  <= mem_g[b_rd_addr];
    end
  end

  // Monitors: pop the scoreboard on every write and log event cycles.
  int a_wr_cnt = 0, a_done_cnt = 0, a_busy_cnt = 0, a_rd_cnt = 0;
  int a_done_cyc = -1, a_busy_rise = -1;
  int a_wr_cyc [1024];
  logic a_busy_prev = 1'b0;
  int b_wr_cnt = 0, b_done_cnt = 0, b_busy_cnt = 0, b_rd_cnt = 0;
  int b_done_cyc = -1, b_busy_rise = -1, b_rd_last = -1;
  int b_wr_cyc [1024];
  logic b_busy_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (a_busy) check("a_sig_in", $signed(a_sig_in), a_rd_gate);
    if (a_wr_en) begin
      if (a_wr_cnt < 1024) a_wr_cyc[a_wr_cnt] = cyc;
      a_wr_cnt++;
      if (q_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_wr: addr %0d data %0d with empty scoreboard", a_wr_addr, $signed(a_wr_data));
      end else begin
        e = q_a.pop_front();
        $display("a write: cycle %0d addr %0d data %0d (exp %0d @ %0d)", cyc, a_wr_addr, $signed(a_wr_data), e.data, e.addr);
        check("a_wr_addr", {28'd0, a_wr_addr}, {28'd0, e.addr});
        check("a_wr_data", $signed(a_wr_data), e.data);
      end
    end
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
    if (a_busy) a_busy_cnt++;
    if (a_busy && !a_busy_prev) a_busy_rise = cyc;
    a_busy_prev = a_busy;
    if (a_rd_en) a_rd_cnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_busy) check("b_sig_in", $signed(b_sig_in), b_rd_gate);
    if (b_wr_en) begin
      if (b_wr_cnt < 1024) b_wr_cyc[b_wr_cnt] = cyc;
      b_wr_cnt++;
      if (q_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_wr: addr %0d data %0d with empty scoreboard", b_wr_addr, $signed(b_wr_data));
      end else begin
        e = q_b.pop_front();
        $display("b write: cycle %0d addr %0d data %0d (exp %0d @ %0d)", cyc, b_wr_addr, $signed(b_wr_data), e.data, e.addr);
        check("b_wr_addr", {28'd0, b_wr_addr}, {28'd0, e.addr});
        check("b_wr_data", $signed(b_wr_data), e.data);
      end
    end
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
    if (b_busy) b_busy_cnt++;
    if (b_busy && !b_busy_prev) b_busy_rise = cyc;
    b_busy_prev = b_busy;
    if (b_rd_en) begin b_rd_cnt++; b_rd_last = cyc; end
  end

  task automatic fill_random();
    for (int k = 0; k < 16; k++) begin
      mem_v[k] = 16'($urandom);
      mem_g[k] = 16'($urandom);
    end
  endtask

  task automatic model_all();
    for (int k = 0; k < 16; k++) exp_v[k] = glu_ref(mem_v[k], mem_g[k]);
  endtask

  // One run of the 9-element instance; abort_off < 0 means no abort,
  // otherwise abort is held in cycle T+abort_off.
  task automatic run_a(input bit poke, input int abort_off);
    int t, nexp, s_wr, s_done, s_busy, s_rd;
    nexp = (abort_off < 0) ? 9 : ((abort_off > 3) ? abort_off - 3 : 0);
    for (int k = 0; k < nexp; k++) q_a.push_back('{addr: AW'(k), data: exp_v[k]});
    s_wr = a_wr_cnt; s_done = a_done_cnt; s_busy = a_busy_cnt; s_rd = a_rd_cnt;
    @(negedge clk);
    a_start = 1'b1;
    t = cyc;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      a_start = poke && (cyc == t + 3 || cyc == t + 13);
      a_abort = (abort_off >= 0) && (cyc == t + abort_off);
    end
    a_start = 1'b0;
    a_abort = 1'b0;
    check("a_wr_count", a_wr_cnt - s_wr, nexp);
    check("a_sb_empty", q_a.size(), 0);
    if (abort_off < 0) begin
      check("a_first_wr_cyc", a_wr_cyc[s_wr], t + 4);
      check("a_last_wr_cyc", a_wr_cyc[s_wr + 8], t + 12);
      check("a_done_count", a_done_cnt - s_done, 1);
      check("a_done_cyc", a_done_cyc, t + 13);
      check("a_busy_rise", a_busy_rise, t + 1);
      check("a_busy_cycles", a_busy_cnt - s_busy, 12);
      check("a_rd_count", a_rd_cnt - s_rd, 9);
    end else begin
      check("a_abort_done", a_done_cnt - s_done, 0);
      check("a_abort_busy", a_busy_cnt - s_busy, abort_off);
      check("a_abort_rd", a_rd_cnt - s_rd, abort_off);
    end
  endtask

  // Two back-to-back runs of the 1-element instance, second start at T+6.
  task automatic run_b();
    int t, s_wr, s_done, s_busy, s_rd;
    q_b.push_back('{addr: '0, data: exp_v[0]});
    q_b.push_back('{addr: '0, data: exp_v[0]});
    s_wr = b_wr_cnt; s_done = b_done_cnt; s_busy = b_busy_cnt; s_rd = b_rd_cnt;
    @(negedge clk);
    b_start = 1'b1;
    t = cyc;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_start = (cyc == t + 6);
    end
    b_start = 1'b0;
    check("b_wr_count", b_wr_cnt - s_wr, 2);
    check("b_sb_empty", q_b.size(), 0);
    check("b_wr1_cyc", b_wr_cyc[s_wr], t + 4);
    check("b_wr2_cyc", b_wr_cyc[s_wr + 1], t + 10);
    check("b_done_count", b_done_cnt - s_done, 2);
    check("b_done_cyc", b_done_cyc, t + 11);
    check("b_rd_count", b_rd_cnt - s_rd, 2);
    check("b_rd_last", b_rd_last, t + 7);
    check("b_busy_rise", b_busy_rise, t + 7);
    check("b_busy_cycles", b_busy_cnt - s_busy, 8);
  endtask

  initial begin
    int t, s_wr, s_rd, s_busy;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, a_busy}, 0);
    check("rst_done", {31'd0, a_done}, 0);
    check("rst_rd_en", {31'd0, a_rd_en}, 0);
    check("rst_rd_addr", {28'd0, a_rd_addr}, 0);
    check("rst_wr_en", {31'd0, a_wr_en}, 0);
    check("rst_wr_addr", {28'd0, a_wr_addr}, 0);
    check("rst_wr_data", {16'd0, a_wr_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 16; k++) begin mem_v[k] = 16'sd4096; mem_g[k] = 16'sd0; end
    for (int k = 0; k < 16; k++) exp_v[k] = 16'sd2048;
    run_a(1'b0, -1);

    fill_random();
    mem_v[0] = -16'sd8192; mem_g[0] = 16'sd8192;
    mem_v[1] = 16'sd4096;  mem_g[1] = -16'sd8192;
    mem_v[2] = 16'sd1000;  mem_g[2] = 16'sd4096;
    mem_v[3] = 16'sd3;     mem_g[3] = 16'sd0;
    mem_v[4] = -16'sd3;    mem_g[4] = 16'sd0;
    mem_v[5] = 16'sd32767; mem_g[5] = 16'sd20000;
    model_all();
    exp_v[0] = -16'sd8192; exp_v[1] = 16'sd0; exp_v[2] = 16'sd750;
    exp_v[3] = 16'sd2;     exp_v[4] = -16'sd1; exp_v[5] = 16'sd32767;
    run_a(1'b0, -1);

    for (int r = 0; r < 5; r++) begin
      fill_random();
      model_all();
      run_a(1'b0, -1);
    end

    fill_random(); model_all();
    run_a(1'b0, 4);
    fill_random(); model_all();
    run_a(1'b1, -1);

    s_rd = a_rd_cnt; s_busy = a_busy_cnt;
    @(negedge clk);
    a_start = 1'b1; a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_abort = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_abort_rd", a_rd_cnt - s_rd, 0);
    check("idle_abort_busy", a_busy_cnt - s_busy, 0);

    fill_random(); model_all();
    s_wr = a_wr_cnt;
    @(negedge clk);
    a_start = 1'b1;
    t = cyc;
    @(negedge clk);
    a_start = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, a_busy}, 0);
    check("mid_rst_rd_en", {31'd0, a_rd_en}, 0);
    check("mid_rst_rd_addr", {28'd0, a_rd_addr}, 0);
    check("mid_rst_wr_en", {31'd0, a_wr_en}, 0);
    check("mid_rst_wr_data", {16'd0, a_wr_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rst_no_wr", a_wr_cnt - s_wr, 0);
    run_a(1'b0, -1);

    fill_random(); model_all();
    run_b();
    fill_random(); model_all();
    run_b();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
